// File: rtl/seg_snoop_tx.sv
// seg_snoop_tx: watches an NDIGITS-wide seven-segment bus and decodes each
// digit to ASCII ('0'-'9', 'a'-'f', '.' for unknown glyphs). Once the display
// has been stable for STABLE cycles on a new value, or on a force request, it
// streams one text frame over a byte-wide valid/ready interface.
//
// Frame: digits NDIGITS-1..0, then CR, then LF. If SEG_SNOOP_COLON_EN is
// defined, a ':' is inserted before each odd digit index below NDIGITS-1.
//
// Ports:
//   clk12m       system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   segments     7*NDIGITS segment bus, digit i = [7i+6:7i] = {g,f,e,d,c,b,a}
//   force_req    one-cycle pulse requesting a frame even if unchanged
//   tx_ready     downstream accepts a byte this cycle
//   tx_data      frame byte
//   tx_data_rdy  tx_data is valid
//   bad_glyph    high while sending a frame that contains a '.'
//   frame_cnt    completed frames, wraps modulo 2^16
module seg_snoop_tx #(
  parameter int NDIGITS = 4,
  parameter int STABLE  = 4
) (
  input  logic                 clk12m,
  input  logic                 rst_n,
  input  logic [7*NDIGITS-1:0] segments,
  input  logic                 force_req,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_rdy,
  output logic                 bad_glyph,
  output logic [15:0]          frame_cnt
);

`ifdef SEG_SNOOP_COLON_EN
  localparam int NCOL = (NDIGITS - 1) / 2;
`else
  localparam int NCOL = 0;
`endif
  localparam int FLEN = NDIGITS + NCOL + 2;
  localparam int IW   = $clog2(FLEN);
  localparam logic [IW-1:0] LAST = IW'(FLEN - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [7*NDIGITS-1:0] r_seg_q, r_snap, w_src;
  logic [7:0]           r_stab;
  logic                 r_force_pend;
  logic [IW-1:0]        r_idx, w_nidx;
  logic [7:0]           r_tx_data;
  logic                 r_rdy, r_bad;
  logic [15:0]          r_frame_cnt;
  logic [7:0]           w_frame [FLEN];
  logic                 w_bad, w_launch, w_xfer, w_last;

  function automatic logic [7:0] dec7(input logic [6:0] s);
    case (s)
      7'h3F: dec7 = 8'h30;  7'h06: dec7 = 8'h31;
      7'h5B: dec7 = 8'h32;  7'h4F: dec7 = 8'h33;
      7'h66: dec7 = 8'h34;  7'h6D: dec7 = 8'h35;
      7'h7D: dec7 = 8'h36;  7'h07: dec7 = 8'h37;
      7'h7F: dec7 = 8'h38;  7'h67: dec7 = 8'h39;
      7'h77: dec7 = 8'h61;  7'h7C: dec7 = 8'h62;
      7'h39: dec7 = 8'h63;  7'h5E: dec7 = 8'h64;
      7'h79: dec7 = 8'h65;  7'h71: dec7 = 8'h66;
      default: dec7 = 8'h2E;
    endcase
  endfunction

  // In IDLE the frame is built from seg_q so the first byte can be launched
  // in the same edge that loads snap; during SEND it comes from snap only.
  assign w_src = (r_state == IDLE) ? r_seg_q : r_snap;

  always_comb begin
    int p;
    p     = 0;
    w_bad = 1'b0;
    for (int k = 0; k < FLEN; k++) w_frame[k] = 8'h00;
    for (int d = NDIGITS - 1; d >= 0; d--) begin
`ifdef SEG_SNOOP_COLON_EN
      if ((d % 2 == 1) && (d < NDIGITS - 1)) begin
        w_frame[p] = 8'h3A;
        p++;
      end
`endif
      w_frame[p] = dec7(w_src[7*d +: 7]);
      if (w_frame[p] == 8'h2E) w_bad = 1'b1;
      p++;
    end
    w_frame[p]   = 8'h0D;
    w_frame[p+1] = 8'h0A;
  end

  // FSM: state register
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_launch)          w_state_nxt = SEND;
      SEND: if (w_xfer && w_last)  w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  // FSM: control decode
  always_comb begin
    w_launch = (r_state == IDLE) &&
               (((r_stab == 8'(STABLE)) && (r_seg_q != r_snap)) || r_force_pend);
    w_xfer   = (r_state == SEND) && r_rdy && tx_ready;
    w_last   = (r_idx == LAST);
    w_nidx   = w_last ? '0 : r_idx + 1'b1;
  end

  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q      <= '0;
      r_snap       <= '0;
      r_stab       <= '0;
      r_force_pend <= 1'b0;
      r_idx        <= '0;
      r_tx_data    <= 8'h00;
      r_rdy        <= 1'b0;
      r_bad        <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_seg_q <= segments;
      if (segments != r_seg_q)        r_stab <= '0;
      else if (r_stab != 8'(STABLE))  r_stab <= r_stab + 1'b1;

      // A request arriving on the launch edge itself is kept for a new frame.
      if (force_req)     r_force_pend <= 1'b1;
      else if (w_launch) r_force_pend <= 1'b0;

      if (w_launch) begin
        r_snap    <= r_seg_q;
        r_idx     <= '0;
        r_tx_data <= w_frame[0];
        r_rdy     <= 1'b1;
        r_bad     <= w_bad;
      end else if (w_xfer) begin
        if (w_last) begin
          r_rdy       <= 1'b0;
          r_bad       <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_idx     <= w_nidx;
          r_tx_data <= w_frame[w_nidx];
        end
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_data_rdy = r_rdy;
  assign bad_glyph   = r_bad;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_seg_snoop_tx.sv
module tb_seg_snoop_tx;
  localparam int ND = 4;
  localparam int ST = 4;

`ifdef SEG_SNOOP_COLON_EN
  localparam int FL = 7;
  localparam logic [7:0] E5910 [FL] = '{8'h35, 8'h39, 8'h3A, 8'h31, 8'h30, 8'h0D, 8'h0A};
  localparam logic [7:0] E5911 [FL] = '{8'h35, 8'h39, 8'h3A, 8'h31, 8'h31, 8'h0D, 8'h0A};
  localparam logic [7:0] EBAD  [FL] = '{8'h2E, 8'h39, 8'h3A, 8'h31, 8'h30, 8'h0D, 8'h0A};
`else
  localparam int FL = 6;
  localparam logic [7:0] E5910 [FL] = '{8'h35, 8'h39, 8'h31, 8'h30, 8'h0D, 8'h0A};
  localparam logic [7:0] E5911 [FL] = '{8'h35, 8'h39, 8'h31, 8'h31, 8'h0D, 8'h0A};
  localparam logic [7:0] EBAD  [FL] = '{8'h2E, 8'h39, 8'h31, 8'h30, 8'h0D, 8'h0A};
`endif

  localparam logic [27:0] S5910 = {7'h6D, 7'h67, 7'h06, 7'h3F};
  localparam logic [27:0] S5911 = {7'h6D, 7'h67, 7'h06, 7'h06};
  localparam logic [27:0] SBAD  = {7'h40, 7'h67, 7'h06, 7'h3F};
  localparam logic [27:0] SGL   = {7'h06, 7'h06, 7'h06, 7'h06};

  logic        clk12m = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] segments = '0;
  logic        force_req = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_data_rdy, bad_glyph;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  cap [16];
  logic        cap_bad [16];
  int          cap_n;
  int          lat;

  seg_snoop_tx #(.NDIGITS(ND), .STABLE(ST)) dut (
    .clk12m(clk12m), .rst_n(rst_n), .segments(segments), .force_req(force_req),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy),
    .bad_glyph(bad_glyph), .frame_cnt(frame_cnt)
  );

  always #5 clk12m = ~clk12m;

  function automatic bit frame_match(input logic [7:0] e [FL]);
    bit ok;
    ok = (cap_n == FL);
    for (int k = 0; k < FL; k++) if (cap[k] !== e[k]) ok = 1'b0;
    return ok;
  endfunction

  task automatic do_reset();
    @(posedge clk12m); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk12m);
    #1 rst_n = 1'b1;
  endtask

  // Count edges until tx_data_rdy is seen high, bounded.
  task automatic wait_rdy();
    lat = 0;
    while (!tx_data_rdy && lat < 40) begin
      @(posedge clk12m); #1;
      lat++;
    end
    checks++;
    if (!tx_data_rdy) begin
      errors++;
      $display("FAIL frame_timeout: tx_data_rdy=0 after %0d edges, required 1", lat);
    end
  endtask

  // Record one frame with tx_ready high; optionally change the bus when the
  // byte with index chg_at is on tx_data.
  task automatic get_frame(input int chg_at, input logic [27:0] chg_val);
    cap_n = 0;
    wait_rdy();
    while (tx_data_rdy && cap_n < 16) begin
      if (cap_n == chg_at) segments = chg_val;
      cap[cap_n]     = tx_data;
      cap_bad[cap_n] = bad_glyph;
      cap_n++;
      @(posedge clk12m); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b, required 0", tx_data_rdy); end
    checks++; if (bad_glyph !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b, required 0", bad_glyph); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", frame_cnt); end
    repeat (3) @(posedge clk12m);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk12m);
    #1;
    checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL idle_blank: rdy=%b, required 0", tx_data_rdy); end
  endtask

  task automatic test_basic();
    bit anybad;
    segments = S5910;
    get_frame(-1, '0);
    checks++; if (lat != 6) begin errors++; $display("FAIL basic_latency: got %0d edges, required 6", lat); end
    checks++;
    if (!frame_match(E5910)) begin
      errors++;
      $display("FAIL basic_frame: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    anybad = 1'b0;
    for (int k = 0; k < cap_n; k++) if (cap_bad[k] !== 1'b0) anybad = 1'b1;
    checks++; if (anybad) begin errors++; $display("FAIL basic_bad: bad_glyph=1 seen, required 0"); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_glitch();
    bit seen;
    segments = SGL;
    repeat (3) @(posedge clk12m);
    #1 segments = S5910;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk12m); #1;
      if (tx_data_rdy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL glitch_rdy: rdy=1 seen, required 0"); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL glitch_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    bit held;
    tx_ready = 1'b0;
    do_reset();
    wait_rdy();
    held = 1'b1;
    repeat (10) begin
      @(posedge clk12m); #1;
      if (tx_data !== 8'h35 || tx_data_rdy !== 1'b1) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL bp_hold: tx_data=%h rdy=%b, required 35/1", tx_data, tx_data_rdy); end
    tx_ready = 1'b1;
    get_frame(-1, '0);
    checks++;
    if (!frame_match(E5910)) begin
      errors++;
      $display("FAIL bp_frame: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_change_during();
    do_reset();
    get_frame(1, S5911);
    checks++;
    if (!frame_match(E5910)) begin
      errors++;
      $display("FAIL chg_first: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    get_frame(-1, '0);
    checks++;
    if (!frame_match(E5911)) begin
      errors++;
      $display("FAIL chg_second: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL chg_cnt: got %0d, required 2", frame_cnt); end
  endtask

  task automatic test_bad_force();
    bit allbad;
    segments = SBAD;
    get_frame(-1, '0);
    checks++;
    if (!frame_match(EBAD)) begin
      errors++;
      $display("FAIL bad_frame: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    allbad = (cap_n > 0);
    for (int k = 0; k < cap_n; k++) if (cap_bad[k] !== 1'b1) allbad = 1'b0;
    checks++; if (!allbad) begin errors++; $display("FAIL bad_flag: bad_glyph not 1 throughout, required 1"); end
    checks++; if (bad_glyph !== 1'b0) begin errors++; $display("FAIL bad_clear: got %b, required 0", bad_glyph); end
    repeat (3) @(posedge clk12m);
    #1 force_req = 1'b1;
    @(posedge clk12m); #1 force_req = 1'b0;
    get_frame(-1, '0);
    checks++; if (lat + 1 != 2) begin errors++; $display("FAIL force_latency: got %0d edges, required 2", lat + 1); end
    checks++;
    if (!frame_match(EBAD)) begin
      errors++;
      $display("FAIL force_frame: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL force_cnt: got %0d, required 4", frame_cnt); end
  endtask

  task automatic test_mid_reset();
    segments = S5910;
    wait_rdy();
    repeat (2) @(posedge clk12m);
    #1;
    checks++; if (tx_data !== E5910[2]) begin errors++; $display("FAIL mr_third: got %h, required %h", tx_data, E5910[2]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_data_rdy !== 1'b0) begin errors++; $display("FAIL mr_rdy: got %b, required 0", tx_data_rdy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mr_cnt: got %0d, required 0", frame_cnt); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mr_data: got %h, required 00", tx_data); end
    @(posedge clk12m); #1 rst_n = 1'b1;
    get_frame(-1, '0);
    checks++;
    if (!frame_match(E5910)) begin
      errors++;
      $display("FAIL mr_frame: got n=%0d %h %h %h %h %h %h %h, required n=%0d", cap_n,
               cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], FL);
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mr_cnt_after: got %0d, required 1", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_backpressure();
    test_change_during();
    test_bad_force();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
